// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: register offsets, STATUS layout and receiver state
// shared by the UART receive peripheral.
package uart_rx_pkg;

    localparam logic [3:0] UART_RX_DATA   = 4'h0;
    localparam logic [3:0] UART_RX_STATUS = 4'h4;
    localparam logic [3:0] UART_RX_DIV    = 4'h8;

    localparam int ST_NOT_EMPTY = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVERRUN   = 2;
    localparam int ST_FRAME_ERR = 3;
    localparam int ST_COUNT_LSB = 8;

    localparam logic [15:0] MIN_DIV = 16'd4;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    function automatic logic [15:0] clamp_div(input logic [15:0] d);
        return (d < MIN_DIV) ? MIN_DIV : d;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with first-word-fall-through output.
// A pop on empty is ignored; a push on full succeeds only with a pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

endmodule

// File: rtl/uart_rx_ip.sv
// uart_rx_ip: 8N1 UART receiver with receive FIFO and DATA/STATUS/DIV
// registers on the local peripheral bus.
module uart_rx_ip
    import uart_rx_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd234
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] waddr,
    input  logic [31:0] wdata,
    input  logic        wen,
    input  logic [3:0]  wstrb,
    output logic        wready,
    input  logic [31:0] raddr,
    input  logic        ren,
    output logic [31:0] rdata,
    output logic        rvalid,
    input  logic        i_uart_rx
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic rx_s1;
    logic rx_s2;
    logic rx_prev;
    logic fall;

    rx_state_t   state, state_nx;
    logic [15:0] cnt, cnt_nx;
    logic [15:0] div_q;
    logic [15:0] div_lat, div_lat_nx;
    logic [2:0]  idx, idx_nx;
    logic [7:0]  shreg, shreg_nx;
    logic        expired;
    logic        push;
    logic        ferr_set;

    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;
    logic          pop;

    logic        ovr_q;
    logic        ferr_q;
    logic        ovr_set;
    logic        clr_ovr;
    logic        clr_ferr;
    logic        div_wr;
    logic [15:0] div_new;
    logic [3:0]  rd_off;
    logic [3:0]  wr_off;
    logic [31:0] status_w;
    logic [31:0] rdata_nx;
    logic        unused;

    assign unused = ^{raddr[31:4], waddr[31:4], wdata[31:16], wstrb[3:2]};

    assign rd_off = raddr[3:0];
    assign wr_off = waddr[3:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= i_uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign fall    = rx_prev & ~rx_s2;
    assign expired = (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            div_lat <= DEFAULT_DIV;
            idx     <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            div_lat <= div_lat_nx;
            idx     <= idx_nx;
            shreg   <= shreg_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = expired ? cnt : cnt - 16'd1;
        div_lat_nx = div_lat;
        idx_nx     = idx;
        shreg_nx   = shreg;
        push       = 1'b0;
        ferr_set   = 1'b0;
        unique case (state)
            IDLE: begin
                if (fall) begin
                    div_lat_nx = div_q;
                    cnt_nx     = div_q >> 1;
                    state_nx   = START;
                end
            end
            START: begin
                if (expired) begin
                    if (!rx_s2) begin
                        cnt_nx   = div_lat - 16'd1;
                        idx_nx   = '0;
                        state_nx = DATA;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            DATA: begin
                if (expired) begin
                    shreg_nx = {rx_s2, shreg[7:1]};
                    cnt_nx   = div_lat - 16'd1;
                    idx_nx   = idx + 3'd1;
                    if (idx == 3'd7) state_nx = STOP;
                end
            end
            STOP: begin
                if (expired) begin
                    push     = rx_s2;
                    ferr_set = !rx_s2;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign pop     = ren && (rd_off == UART_RX_DATA) && !fifo_empty;
    assign ovr_set = push && fifo_full && !pop;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (shreg),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign clr_ovr  = wen && (wr_off == UART_RX_STATUS)
                    && wstrb[0] && wdata[ST_OVERRUN];
    assign clr_ferr = wen && (wr_off == UART_RX_STATUS)
                    && wstrb[0] && wdata[ST_FRAME_ERR];
    assign div_wr   = wen && (wr_off == UART_RX_DIV);
    assign div_new  = {wstrb[1] ? wdata[15:8] : div_q[15:8],
                       wstrb[0] ? wdata[7:0]  : div_q[7:0]};

    always_comb begin
        status_w = '0;
        status_w[ST_NOT_EMPTY] = !fifo_empty;
        status_w[ST_FULL]      = fifo_full;
        status_w[ST_OVERRUN]   = ovr_q;
        status_w[ST_FRAME_ERR] = ferr_q;
        status_w[ST_COUNT_LSB +: 8] = 8'(fifo_count);
    end

    always_comb begin
        rdata_nx = '0;
        unique case (1'b1)
            (rd_off == UART_RX_DATA): begin
                if (!fifo_empty) rdata_nx = {23'd0, 1'b1, fifo_dout};
            end
            (rd_off == UART_RX_STATUS): rdata_nx = status_w;
            (rd_off == UART_RX_DIV):    rdata_nx = {16'd0, div_q};
            default:                    rdata_nx = '0;
        endcase
    end

    // a new error event wins over a clear landing in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q  <= DEFAULT_DIV;
            ovr_q  <= 1'b0;
            ferr_q <= 1'b0;
            wready <= 1'b0;
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            if (div_wr) div_q <= clamp_div(div_new);
            ovr_q  <= (ovr_q & ~clr_ovr) | ovr_set;
            ferr_q <= (ferr_q & ~clr_ferr) | ferr_set;
            wready <= wen;
            rvalid <= ren;
            if (ren) rdata <= rdata_nx;
            else     rdata <= '0;
        end
    end

endmodule

// File: tb/tb_uart_rx_ip.sv
// tb_uart_rx_ip: directed checks of the UART receive peripheral:
// framing, FIFO full/overrun, frame errors, glitches, reset.
module tb_uart_rx_ip;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        wen;
    logic [3:0]  wstrb;
    logic        wready;
    logic [31:0] raddr;
    logic        ren;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rx;

    int          total  = 0;
    int          passed = 0;
    logic [31:0] v;

    always #5 clk = ~clk;

    uart_rx_ip dut (
        .clk       (clk),
        .rst       (rst),
        .waddr     (waddr),
        .wdata     (wdata),
        .wen       (wen),
        .wstrb     (wstrb),
        .wready    (wready),
        .raddr     (raddr),
        .ren       (ren),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .i_uart_rx (rx)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h",
                    tag, obs, exp);
    endtask

    task automatic drive_bit(input logic b, input int d);
        #1 rx = b;
        repeat (d) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b,
                             input int d,
                             input logic stop);
        @(posedge clk);
        drive_bit(1'b0, d);
        for (int i = 0; i < 8; i++) drive_bit(b[i], d);
        drive_bit(stop, d);
        #1 rx = 1'b1;
        repeat (2 * d + 6) @(posedge clk);
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        @(posedge clk);
        #1 raddr = {28'd0, a};
        ren = 1'b1;
        @(posedge clk);
        #1 ren = 1'b0;
        d = rdata;
        chk("rvalid", {31'd0, rvalid}, 32'd1);
    endtask

    task automatic wr(input logic [3:0] a,
                      input logic [31:0] d,
                      input logic [3:0] s);
        @(posedge clk);
        #1 waddr = {28'd0, a};
        wdata = d;
        wstrb = s;
        wen = 1'b1;
        @(posedge clk);
        #1 wen = 1'b0;
        chk("wready", {31'd0, wready}, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        wen = 1'b0;
        ren = 1'b0;
        rx = 1'b1;
        waddr = '0;
        wdata = '0;
        raddr = '0;
        wstrb = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst_wready", {31'd0, wready}, 32'd0);
        rst = 1'b0;
        rd(4'h4, v); chk("rst_status", v, 32'h0000_0000);
        rd(4'h8, v); chk("rst_div", v, 32'h0000_00EA);

        send_byte(8'hA5, 234, 1'b1);
        rd(4'h4, v); chk("a5_status", v, 32'h0000_0101);
        rd(4'h0, v); chk("a5_data", v, 32'h0000_01A5);
        rd(4'h4, v); chk("a5_status2", v, 32'h0000_0000);
        rd(4'h0, v); chk("empty_data", v, 32'h0000_0000);

        wr(4'h8, 32'h0000_0002, 4'b0011);
        rd(4'h8, v); chk("div_clamp", v, 32'h0000_0004);
        send_byte(8'h3C, 4, 1'b1);
        rd(4'h0, v); chk("3c_data", v, 32'h0000_013C);

        wr(4'h8, 32'h0000_AB10, 4'b0001);
        rd(4'h8, v); chk("div_bytelane", v, 32'h0000_0010);

        for (int i = 0; i < 9; i++) send_byte(8'(i), 16, 1'b1);
        rd(4'h4, v); chk("ovr_status", v, 32'h0000_0807);
        for (int i = 0; i < 8; i++) begin
            rd(4'h0, v); chk("drain", v, 32'h100 + 32'(i));
        end
        rd(4'h0, v); chk("drain_empty", v, 32'h0000_0000);
        rd(4'h4, v); chk("ovr_sticky", v, 32'h0000_0004);
        wr(4'h4, 32'h0000_0004, 4'b0001);
        rd(4'h4, v); chk("ovr_clear", v, 32'h0000_0000);

        send_byte(8'h55, 16, 1'b0);
        rd(4'h4, v); chk("ferr_status", v, 32'h0000_0008);
        wr(4'h4, 32'h0000_0008, 4'b0001);
        rd(4'h4, v); chk("ferr_clear", v, 32'h0000_0000);

        @(posedge clk);
        #1 rx = 1'b0;
        repeat (320) @(posedge clk);
        #1 rx = 1'b1;
        repeat (40) @(posedge clk);
        rd(4'h4, v); chk("break_status", v, 32'h0000_0008);
        wr(4'h4, 32'h0000_0008, 4'b0001);
        rd(4'h4, v); chk("break_clear", v, 32'h0000_0000);

        @(posedge clk);
        #1 rx = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx = 1'b1;
        repeat (40) @(posedge clk);
        rd(4'h4, v); chk("glitch_status", v, 32'h0000_0000);
        send_byte(8'h5A, 16, 1'b1);
        rd(4'h0, v); chk("post_glitch", v, 32'h0000_015A);

        for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i), 16, 1'b1);
        fork
            send_byte(8'h77, 16, 1'b1);
            begin
                @(posedge clk);
                repeat (155) @(posedge clk);
                #1 raddr = 32'h0;
                ren = 1'b1;
                @(posedge clk);
                #1 ren = 1'b0;
                v = rdata;
            end
        join
        chk("simul_data", v, 32'h0000_0110);
        rd(4'h4, v); chk("simul_status", v, 32'h0000_0803);

        @(posedge clk);
        drive_bit(1'b0, 16);
        drive_bit(1'b1, 16);
        drive_bit(1'b0, 16);
        drive_bit(1'b0, 16);
        #1 rx = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        rx = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_rdata", rdata, 32'd0);
        chk("mid_rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("mid_rst_wready", {31'd0, wready}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        rd(4'h4, v); chk("mid_rst_status", v, 32'h0000_0000);
        rd(4'h8, v); chk("mid_rst_div", v, 32'h0000_00EA);
        send_byte(8'h81, 234, 1'b1);
        rd(4'h0, v); chk("81_data", v, 32'h0000_0181);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
